vec_regfile: RTL and testbench

Parametrised vector register file for the vector CPU datapath. It sits between decode and the vector ALU and holds NREGS vector registers of LANES × LANE_W bits. Register 0 doubles as the scalar bank, one scalar per lane. It adds three things over the fixed 16×6×8 file: per-lane write masking, deterministic two-port write merging, and a sequential clear sweep with a `ready` handshake.

---
 rtl/vec_pkg.sv | 21 ++
 rtl/vec_write_merge.sv | 54 +++++
 rtl/vec_regfile.sv | 177 +++++++++++++++++
 tb/tb_vec_regfile.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and defaults for the vector register file
//
// Purpose: default geometry of the vector register file, the lane/vector
// types used by the datapath, and the register-file FSM state encoding.
// Ports: none (package).

package vec_pkg;

  localparam int VEC_LANES  = 6;
  localparam int VEC_LANE_W = 8;
  localparam int VEC_NREGS  = 16;

  typedef logic [VEC_LANE_W-1:0] lane_t;
  typedef lane_t [VEC_LANES-1:0] vec_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/vec_write_merge.sv
// rtl/vec_write_merge.sv - per-lane merge of the two write ports for one register
//
// Purpose: for a given target register, works out which lanes the two write
// ports touch this cycle and with what data. Port A wins on every lane it
// writes; port B fills the remaining lanes of the same register.
// Ports:
//   en        : writes allowed this cycle (RUN and no clear/reset)
//   tgt       : register index being evaluated
//   we_a, ws_a, wa_addr, wd_a, wm_a : port A (vector or scalar write)
//   we_b, wb_addr, wd_b             : port B (full-vector write)
//   lane_en   : per-lane write enable for tgt
//   lane_data : merged per-lane data for tgt

module vec_write_merge #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8,
  parameter int AW     = 4
) (
  input  logic                    en,
  input  logic [AW-1:0]           tgt,
  input  logic                    we_a,
  input  logic                    ws_a,
  input  logic [AW-1:0]           wa_addr,
  input  logic [LANES*LANE_W-1:0] wd_a,
  input  logic [LANES-1:0]        wm_a,
  input  logic                    we_b,
  input  logic [AW-1:0]           wb_addr,
  input  logic [LANES*LANE_W-1:0] wd_b,
  output logic [LANES-1:0]        lane_en,
  output logic [LANES*LANE_W-1:0] lane_data
);
  import vec_pkg::*;

  logic a_vec;
  logic a_scl;
  logic b_hit;

  assign a_vec = en & we_a & ~ws_a & (wa_addr == tgt);
  // Scalar writes always land in register 0; wa_addr selects the lane.
  assign a_scl = en & we_a & ws_a & (tgt == '0);
  assign b_hit = en & we_b & (wb_addr == tgt);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic a_hit;

    // An out-of-range scalar lane index matches no lane, so it writes nothing.
    assign a_hit = (a_vec & wm_a[i]) | (a_scl & (wa_addr == AW'(i)));
    assign lane_en[i] = a_hit | b_hit;
    assign lane_data[i*LANE_W +: LANE_W] =
      a_hit ? (ws_a ? wd_a[LANE_W-1:0] : wd_a[i*LANE_W +: LANE_W])
            : wd_b[i*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/vec_regfile.sv
// rtl/vec_regfile.sv - vector register file with lane masking, port merge and clear sweep
//
// Purpose: NREGS vector registers of LANES x LANE_W bits; register 0 is also
// the scalar bank. After reset or a clr pulse the file sweeps one register
// per cycle to zero and holds ready low until the sweep completes.
// Optional feature: define VEC_REGFILE_BYPASS_EN for write-first reads;
// otherwise reads return pre-edge contents.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clr          : soft-clear request (ignored while clearing)
//   ready        : file usable (low during the sweep)
//   err          : sticky illegal-scalar-write flag
//   we_a, ws_a, wa_addr, wd_a, wm_a : port A write
//   we_b, wb_addr, wd_b             : port B full-vector write
//   ra1, ra2, rs_flag               : read addresses, rd2 scalar-bank select
//   rd1, rd2     : read data

module vec_regfile #(
  parameter int LANES  = vec_pkg::VEC_LANES,
  parameter int LANE_W = vec_pkg::VEC_LANE_W,
  parameter int NREGS  = vec_pkg::VEC_NREGS,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    ready,
  output logic                    err,
  input  logic                    we_a,
  input  logic                    ws_a,
  input  logic [AW-1:0]           wa_addr,
  input  logic [LANES*LANE_W-1:0] wd_a,
  input  logic [LANES-1:0]        wm_a,
  input  logic                    we_b,
  input  logic [AW-1:0]           wb_addr,
  input  logic [LANES*LANE_W-1:0] wd_b,
  input  logic [AW-1:0]           ra1,
  input  logic [AW-1:0]           ra2,
  input  logic                    rs_flag,
  output logic [LANES*LANE_W-1:0] rd1,
  output logic [LANES*LANE_W-1:0] rd2
);
  import vec_pkg::*;

  localparam int VW = LANES * LANE_W;

  rf_state_t     state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          err_q, err_nx;
  logic          run;
  logic          wr_en;
  logic          bad_scalar;

  // Storage has no reset; the sweep is what zeroes it.
  logic [VW-1:0] mem [NREGS];

  assign run   = (state == RUN);
  // clr and reset both win over any write presented in the same cycle.
  assign wr_en = run & rst_n & ~clr;
  assign bad_scalar = wr_en & we_a & ws_a & (int'(wa_addr) >= LANES);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = err_q;
    case (state)
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == AW'(NREGS - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
          err_nx   = 1'b0;
        end else if (bad_scalar) begin
          err_nx = 1'b1;
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
    end
  end

  // Port A's target register; the merge covers port B when it hits the same
  // register, so a later per-lane update overrides B's whole-vector write.
  logic [AW-1:0] wt_addr;
  logic [LANES-1:0] wr_lane_en;
  logic [VW-1:0]    wr_data;

  assign wt_addr = ws_a ? '0 : wa_addr;

  vec_write_merge #(.LANES(LANES), .LANE_W(LANE_W), .AW(AW)) u_wr_merge (
    .en(wr_en), .tgt(wt_addr),
    .we_a(we_a), .ws_a(ws_a), .wa_addr(wa_addr), .wd_a(wd_a), .wm_a(wm_a),
    .we_b(we_b), .wb_addr(wb_addr), .wd_b(wd_b),
    .lane_en(wr_lane_en), .lane_data(wr_data)
  );

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      if (wr_en && we_b) begin
        mem[wb_addr] <= wd_b;
      end
      for (int i = 0; i < LANES; i++) begin
        if (wr_lane_en[i]) begin
          mem[wt_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  logic [AW-1:0] r2_addr;
  logic [VW-1:0] st1, st2;
  logic [VW-1:0] v1, v2;

  assign r2_addr = rs_flag ? '0 : ra2;
  assign st1 = mem[ra1];
  assign st2 = mem[r2_addr];

`ifdef VEC_REGFILE_BYPASS_EN
  logic [LANES-1:0] b1_en, b2_en;
  logic [VW-1:0]    b1_data, b2_data;

  vec_write_merge #(.LANES(LANES), .LANE_W(LANE_W), .AW(AW)) u_byp1 (
    .en(wr_en), .tgt(ra1),
    .we_a(we_a), .ws_a(ws_a), .wa_addr(wa_addr), .wd_a(wd_a), .wm_a(wm_a),
    .we_b(we_b), .wb_addr(wb_addr), .wd_b(wd_b),
    .lane_en(b1_en), .lane_data(b1_data)
  );

  vec_write_merge #(.LANES(LANES), .LANE_W(LANE_W), .AW(AW)) u_byp2 (
    .en(wr_en), .tgt(r2_addr),
    .we_a(we_a), .ws_a(ws_a), .wa_addr(wa_addr), .wd_a(wd_a), .wm_a(wm_a),
    .we_b(we_b), .wb_addr(wb_addr), .wd_b(wd_b),
    .lane_en(b2_en), .lane_data(b2_data)
  );

  always_comb begin
    v1 = st1;
    v2 = st2;
    for (int i = 0; i < LANES; i++) begin
      if (b1_en[i]) v1[i*LANE_W +: LANE_W] = b1_data[i*LANE_W +: LANE_W];
      if (b2_en[i]) v2[i*LANE_W +: LANE_W] = b2_data[i*LANE_W +: LANE_W];
    end
  end
`else
  assign v1 = st1;
  assign v2 = st2;
`endif

  // Contents are not trustworthy mid-sweep, so reads are forced to zero.
  assign rd1   = run ? v1 : '0;
  assign rd2   = run ? v2 : '0;
  assign ready = run;
  assign err   = err_q;

endmodule

// File: tb/tb_vec_regfile.sv
// tb/tb_vec_regfile.sv - directed self-checking bench for vec_regfile

module tb_vec_regfile;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int NREGS  = 16;
  localparam int AW     = 4;
  localparam int VW     = LANES * LANE_W;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          ready;
  logic          err;
  logic          we_a;
  logic          ws_a;
  logic [AW-1:0] wa_addr;
  logic [VW-1:0] wd_a;
  logic [LANES-1:0] wm_a;
  logic          we_b;
  logic [AW-1:0] wb_addr;
  logic [VW-1:0] wd_b;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          rs_flag;
  logic [VW-1:0] rd1;
  logic [VW-1:0] rd2;

  int checks = 0;
  int errors = 0;

  vec_regfile #(.LANES(LANES), .LANE_W(LANE_W), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready), .err(err),
    .we_a(we_a), .ws_a(ws_a), .wa_addr(wa_addr), .wd_a(wd_a), .wm_a(wm_a),
    .we_b(we_b), .wb_addr(wb_addr), .wd_b(wd_b),
    .ra1(ra1), .ra2(ra2), .rs_flag(rs_flag), .rd1(rd1), .rd2(rd2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    we_a = 1'b0; ws_a = 1'b0; we_b = 1'b0; clr = 1'b0;
    wa_addr = '0; wb_addr = '0; wd_a = '0; wd_b = '0; wm_a = '0;
  endtask

  // Counts edges from now until ready is seen high, bounded.
  task automatic edges_to_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 64);
  endtask

  int n;
  int low_cnt;

  initial begin
    idle_writes();
    rst_n = 1'b0; ra1 = '0; ra2 = '0; rs_flag = 1'b0;

    // Reset: three cycles low.
    tick(); tick(); tick();
    check("rst_ready", {47'b0, ready}, 48'h0);
    check("rst_err",   {47'b0, err},   48'h0);
    check("rst_rd1",   rd1, 48'h0);
    check("rst_rd2",   rd2, 48'h0);

    rst_n = 1'b1;
    edges_to_ready(n);
    check("sweep_len", VW'(n), VW'(16));
    for (int r = 0; r < NREGS; r++) begin
      ra1 = AW'(r);
      ra2 = AW'(NREGS - 1 - r);
      #1;
      check($sformatf("sweep_zero_r%0d", r), rd1 | rd2, 48'h0);
    end

    // Masked vector write to reg 3, lanes 0 and 2.
    we_a = 1'b1; wa_addr = 4'd3; wd_a = 48'h060504030201; wm_a = 6'b000101; ra1 = 4'd3;
    tick();
    idle_writes();
    check("masked_write", rd1, 48'h000000030001);

    // Scalar write: lane 2 of reg 0 gets lane 0 of wd_a; other lanes and mask ignored.
    we_a = 1'b1; ws_a = 1'b1; wa_addr = 4'd2; wd_a = 48'h11223344557F; wm_a = 6'b000000;
    tick();
    idle_writes();
    rs_flag = 1'b1; ra2 = 4'd9;
    #1;
    check("scalar_write", rd2, 48'h0000007F0000);
    check("err_clean",    {47'b0, err}, 48'h0);

    // Illegal scalar lane 6.
    we_a = 1'b1; ws_a = 1'b1; wa_addr = 4'd6; wd_a = 48'h000000000033;
    tick();
    idle_writes();
    check("err_set",          {47'b0, err}, 48'h1);
    check("illegal_no_write", rd2, 48'h0000007F0000);
    tick(); tick();
    check("err_sticky",       {47'b0, err}, 48'h1);
    rs_flag = 1'b0;

    // Same-register conflict on reg 11.
    we_a = 1'b1; wa_addr = 4'd11; wd_a = {6{8'hAA}}; wm_a = 6'b000011;
    we_b = 1'b1; wb_addr = 4'd11; wd_b = {6{8'h55}};
    tick();
    idle_writes();
    ra1 = 4'd11;
    #1;
    check("conflict_merge", rd1, 48'h55555555AAAA);

    // Two ports to different registers in one cycle.
    we_a = 1'b1; wa_addr = 4'd5; wd_a = {6{8'h21}}; wm_a = 6'b111111;
    we_b = 1'b1; wb_addr = 4'd7; wd_b = {6{8'h77}};
    tick();
    idle_writes();
    ra1 = 4'd5; ra2 = 4'd7;
    #1;
    check("dual_a", rd1, {6{8'h21}});
    check("dual_b", rd2, {6{8'h77}});

    // Same-cycle read of a register being written.
    ra1 = 4'd4;
    we_a = 1'b1; wa_addr = 4'd4; wd_a = {6{8'h11}}; wm_a = 6'b111111;
    #1;
`ifdef VEC_REGFILE_BYPASS_EN
    check("bypass_same_cycle", rd1, {6{8'h11}});
`else
    check("no_bypass_same_cycle", rd1, 48'h0);
`endif
    tick();
    idle_writes();
    check("bypass_next_cycle", rd1, {6{8'h11}});

    // clr with a simultaneous write; reg 3 holds data and must read 0 mid-sweep.
    ra1 = 4'd3;
    clr = 1'b1; we_b = 1'b1; wb_addr = 4'd12; wd_b = {6{8'hEE}};
    tick();
    idle_writes();
    check("clr_ready_low", {47'b0, ready}, 48'h0);
    check("clr_err_clear", {47'b0, err},   48'h0);
    check("clr_rd_zero",   rd1, 48'h0);
    low_cnt = 1;
    while (low_cnt < 64) begin
      // Writes and clr during the sweep must both be ignored.
      if (low_cnt == 5) begin we_b = 1'b1; wb_addr = 4'd0; wd_b = {6{8'h99}}; end
      if (low_cnt == 8) clr = 1'b1;
      tick();
      idle_writes();
      if (ready) break;
      low_cnt++;
    end
    check("clr_low_len", VW'(low_cnt), VW'(16));
    ra1 = 4'd0; ra2 = 4'd12;
    #1;
    check("clear_write_dropped", rd1, 48'h0);
    check("clr_write_lost",      rd2, 48'h0);
    ra1 = 4'd11;
    #1;
    check("clr_swept_reg11", rd1, 48'h0);

    // Reset at sweep cycle 7 restarts the whole sweep.
    we_b = 1'b1; wb_addr = 4'd2; wd_b = {6{8'h42}};
    tick();
    idle_writes();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst_n = 1'b0;
    tick();
    check("midsweep_rst_ready", {47'b0, ready}, 48'h0);
    rst_n = 1'b1;
    edges_to_ready(n);
    check("midsweep_restart_len", VW'(n), VW'(16));
    ra1 = 4'd2;
    #1;
    check("midsweep_reg2_zero", rd1, 48'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
